// File: rtl/sram_ctrl.sv
// Sequences one CPU access into timed strobes on a 16-bit asynchronous SRAM.
// Define SRAM_CTRL_STATS_EN to build the AccessCount completed-access counter.
module sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  input  logic [1:0]        ByteEn,
  output logic              Busy,
  output logic              Ready,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] A,
  inout  wire  [DATA_W-1:0] Data_Mem,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [15:0]       AccessCount
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              ready_q;
  logic              drive_q;
  logic              ce_q;
  logic              ub_q;
  logic              lb_q;
  logic              oe_q;
  logic              we_q;
  logic [DATA_W-1:0] byteMask;

  // Deselected byte lanes read back as zero regardless of what the bus floats to.
  assign byteMask = {{(DATA_W/2){be_q[1]}}, {(DATA_W/2){be_q[0]}}};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      a_q     <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      drive_q <= 1'b0;
      ce_q    <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req) begin
            wr_q    <= Wr;
            wdata_q <= WData;
            be_q    <= ByteEn;
            if (ByteEn != 2'b00) begin
              state_q <= SETUP;
              busy_q  <= 1'b1;
              a_q     <= Addr;
              ce_q    <= 1'b0;
              ub_q    <= ~ByteEn[1];
              lb_q    <= ~ByteEn[0];
              drive_q <= Wr;
            end else begin
              ready_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= CNT_LOAD;
          if (wr_q) begin
            we_q <= 1'b0;
          end else begin
            oe_q <= 1'b0;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= HOLD;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ready_q <= 1'b1;
            if (!wr_q) begin
              rdata_q <= Data_Mem & byteMask;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          // Write data stays on the bus through this cycle for SRAM hold time.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
          ce_q    <= 1'b1;
          ub_q    <= 1'b1;
          lb_q    <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data_Mem = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign Busy     = busy_q;
  assign Ready    = ready_q;
  assign RData    = rdata_q;
  assign A        = a_q;
  assign CE       = ce_q;
  assign UB       = ub_q;
  assign LB       = lb_q;
  assign OE       = oe_q;
  assign WE       = we_q;

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (ready_q) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign AccessCount = count_q;
`else
  assign AccessCount = '0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural async SRAM on the data bus.
// Stimulus pushes expected RData per access; a monitor pops on every Ready.
module tb_sram_ctrl;

  localparam int W = 2;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic        Wr;
  logic [19:0] Addr;
  logic [15:0] WData;
  logic [1:0]  ByteEn;
  logic        Busy;
  logic        Ready;
  logic [15:0] RData;
  logic [19:0] A;
  wire  [15:0] Data_Mem;
  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [15:0] AccessCount;

  logic        probeEn;
  logic [15:0] mem [0:255];
  logic [15:0] expQ [$];
  logic [15:0] popped;
  int          total;
  int          bad;

  sram_ctrl #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(W)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
    .ByteEn(ByteEn), .Busy(Busy), .Ready(Ready), .RData(RData), .A(A),
    .Data_Mem(Data_Mem), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .AccessCount(AccessCount)
  );

  // The SRAM drives on a read strobe; otherwise a zero probe exposes any stray DUT drive.
  assign Data_Mem = (!CE && !OE && WE) ? mem[A[7:0]] : (probeEn ? 16'h0000 : 16'hzzzz);

  always @(posedge WE) begin
    if (!CE) begin
      if (!UB) mem[A[7:0]][15:8] = Data_Mem[15:8];
      if (!LB) mem[A[7:0]][7:0]  = Data_Mem[7:0];
    end
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset && Ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedReady: got Ready with empty queue, expected none");
      end else begin
        popped = expQ.pop_front();
        checkOutput("rdata", 32'(RData), 32'(popped));
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [19:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be, input logic [15:0] expRdata);
    logic oeExp;
    logic weExp;
    Req = 1'b1; Wr = wr; Addr = addr; WData = wdata; ByteEn = be;
    if (wr) probeEn = 1'b0;
    expQ.push_back(expRdata);
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge Clk); #1;
      if (i == 1) Req = 1'b0;
      if (i <= W + 2) begin
        oeExp = !(!wr && i >= 2 && i <= W + 1);
        weExp = !(wr && i >= 2 && i <= W + 1);
        checkOutput($sformatf("busy%0d", i), 32'(Busy), 32'd1);
        checkOutput($sformatf("strobes%0d", i), 32'({CE, UB, LB, OE, WE}),
                    32'({1'b0, ~be[1], ~be[0], oeExp, weExp}));
        checkOutput($sformatf("addr%0d", i), 32'(A), 32'(addr));
        checkOutput($sformatf("ready%0d", i), 32'(Ready), 32'(i == W + 2));
        if (wr) checkOutput($sformatf("wbus%0d", i), 32'(Data_Mem), 32'(wdata));
        else if (i == 1 || i == W + 2) checkOutput($sformatf("rbusIdle%0d", i), 32'(Data_Mem), 32'h0);
      end else begin
        if (wr) begin probeEn = 1'b1; #1; end
        checkOutput("busyDone", 32'(Busy), 32'd0);
        checkOutput("strobesDone", 32'({CE, UB, LB, OE, WE}), 32'h1F);
        checkOutput("readyDone", 32'(Ready), 32'd0);
        checkOutput("busReleased", 32'(Data_Mem), 32'h0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:1] expBusy;
    logic [10:1] expReady;
    total = 0; bad = 0;
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[8'h23] = 16'hBEEF;
    mem[8'hFF] = 16'h1234;
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    Reset = 1'b0; Req = 1'b0; Wr = 1'b0; Addr = '0; WData = '0; ByteEn = '0; probeEn = 1'b1;

    repeat (2) @(negedge Clk); #1;
    checkOutput("rstStrobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    checkOutput("rstAddr", 32'(A), 32'h0);
    checkOutput("rstBusyReady", 32'({Busy, Ready}), 32'h0);
    checkOutput("rstRData", 32'(RData), 32'h0);
    checkOutput("rstCount", 32'(AccessCount), 32'h0);
    checkOutput("rstBus", 32'(Data_Mem), 32'h0);
    Reset = 1'b1;
    @(negedge Clk); #1;

    applyStimulus(1'b0, 20'h00123, 16'h0000, 2'b11, 16'hBEEF);
    applyStimulus(1'b1, 20'h0FFFF, 16'hA55A, 2'b01, 16'hBEEF);
    checkOutput("memAfterWrite", 32'(mem[8'hFF]), 32'h125A);
    applyStimulus(1'b0, 20'h0FFFF, 16'h0000, 2'b01, 16'h005A);

    // Back-to-back reads with Req held high and inputs disturbed mid-access.
    expBusy  = 10'b0111101111;
    expReady = 10'b0100001000;
    Req = 1'b1; Wr = 1'b0; Addr = 20'h00001; ByteEn = 2'b11;
    expQ.push_back(16'h1111);
    expQ.push_back(16'h2222);
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk); #1;
      if (i == 1) begin Addr = 20'h00002; Wr = 1'b1; WData = 16'hFFFF; ByteEn = 2'b00; end
      if (i == 2) begin Wr = 1'b0; ByteEn = 2'b11; end
      if (i == 6) Req = 1'b0;
      checkOutput($sformatf("b2bBusy%0d", i), 32'(Busy), 32'(expBusy[i]));
      checkOutput($sformatf("b2bReady%0d", i), 32'(Ready), 32'(expReady[i]));
      if (i == 4 || i == 5) checkOutput($sformatf("b2bAddrFirst%0d", i), 32'(A), 32'h1);
      if (i == 6) checkOutput("b2bAddrSecond", 32'(A), 32'h2);
    end

    // No-op request: immediate Ready, no strobes, address held.
    Req = 1'b1; Wr = 1'b0; Addr = 20'h00055; ByteEn = 2'b00;
    expQ.push_back(16'h2222);
    @(negedge Clk); #1;
    Req = 1'b0;
    checkOutput("noopReady", 32'(Ready), 32'd1);
    checkOutput("noopBusy", 32'(Busy), 32'd0);
    checkOutput("noopStrobes", 32'({CE, OE, WE}), 32'h7);
    checkOutput("noopAddrHeld", 32'(A), 32'h2);
    @(negedge Clk); #1;
    checkOutput("noopReadyPulse", 32'(Ready), 32'd0);

    // Reset asserted while WE is low.
    Req = 1'b1; Wr = 1'b1; Addr = 20'h00033; WData = 16'h7777; ByteEn = 2'b11; probeEn = 1'b0;
    @(negedge Clk); #1;
    Req = 1'b0;
    @(negedge Clk); #1;
    checkOutput("midWriteWE", 32'(WE), 32'd0);
    Reset = 1'b0;
    @(negedge Clk); #1;
    checkOutput("abortStrobes", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    checkOutput("abortBusyReady", 32'({Busy, Ready}), 32'h0);
    probeEn = 1'b1; #1;
    checkOutput("abortBus", 32'(Data_Mem), 32'h0);
    checkOutput("abortRData", 32'(RData), 32'h0);
    Reset = 1'b1;
    @(negedge Clk); #1;

    applyStimulus(1'b0, 20'h00123, 16'h0000, 2'b10, 16'hBE00);
    repeat (2) @(negedge Clk); #1;

`ifdef SRAM_CTRL_STATS_EN
    checkOutput("countOne", 32'(AccessCount), 32'h1);
    Reset = 1'b0;
    repeat (2) @(negedge Clk); #1;
    Reset = 1'b1;
    checkOutput("countCleared", 32'(AccessCount), 32'h0);
    Req = 1'b1; Wr = 1'b0; ByteEn = 2'b00;
    for (int k = 0; k < 65535; k++) begin
      expQ.push_back(16'h0000);
      @(negedge Clk);
    end
    Req = 1'b0;
    repeat (2) @(negedge Clk); #1;
    checkOutput("countFull", 32'(AccessCount), 32'hFFFF);
    Req = 1'b1;
    expQ.push_back(16'h0000);
    @(negedge Clk);
    Req = 1'b0;
    repeat (2) @(negedge Clk); #1;
    checkOutput("countWrap", 32'(AccessCount), 32'h0);
`else
    checkOutput("countTiedZero", 32'(AccessCount), 32'h0);
`endif

    repeat (3) @(negedge Clk); #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sequences one CPU memory access into a timed strobe sequence on the external 16-bit asynchronous SRAM (address, CE/UB/LB/OE/WE, shared data bus).
- Sits directly downstream of the processor's memory interface, replacing direct combinational strobe drive.
- Uses a request/ready handshake so the CPU state machine can wait on Ready instead of counting fixed memory cycles.

Parameters:
- ADDR_W, 20, width of the SRAM address.
- DATA_W, 16, width of the SRAM data word.
- WAIT_CYC, 2, number of cycles the OE or WE strobe is held active; legal range 1..15.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req  in  1  access request; sampled only in IDLE.
- Wr  in  1  1 = write, 0 = read; sampled with Req.
- Addr  in  ADDR_W  access address; sampled with Req.
- WData  in  DATA_W  write data; sampled with Req.
- ByteEn  in  2  [1] = upper byte, [0] = lower byte; sampled with Req.
- Busy  out  1  high from the cycle after acceptance until the return to IDLE.
- Ready  out  1  one-cycle completion pulse.
- RData  out  DATA_W  read data; valid while Ready is high and held until the next read completes.
- A  out  ADDR_W  SRAM address.
- Data_Mem  inout  DATA_W  SRAM data bus.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, all active-low.
- AccessCount  out  16  count of completed accesses (see Optional Feature).

Behaviour:
- Reset (Reset=0 at a clock edge):
  - FSM goes to IDLE, aborting any access in progress on that edge.
  - CE/UB/LB/OE/WE = 1, A = 0, Busy = 0, Ready = 0, RData = 0, Data_Mem = Z, AccessCount = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If Req=1, latch Wr/Addr/WData/ByteEn.
  - If ByteEn != 00, go to SETUP and set Busy=1.
  - If ByteEn == 00 (no-op), stay in IDLE, pulse Ready next cycle, and assert no strobe.
- SETUP (1 cycle):
  - A = latched address, CE = 0, UB = ~ByteEn[1], LB = ~ByteEn[0].
  - OE = WE = 1.
  - Data_Mem is driven with WData when writing, Z when reading.
- STROBE (WAIT_CYC cycles, internal down-counter):
  - Read: OE = 0.
  - Write: WE = 0 and Data_Mem driven.
  - Read capture: at the edge ending the last STROBE cycle, RData <= Data_Mem. Masked bytes capture as 0.
- HOLD (1 cycle):
  - OE = WE = 1, CE = 0, address held.
  - Write data remains driven (hold time).
  - Ready = 1 for exactly this cycle.
  - Next state is IDLE; strobes go to 1, Busy = 0, Data_Mem = Z.
- Latency: Ready is high WAIT_CYC+2 cycles after the accepting edge. Default: 4.
- Back-to-back: Req held high during HOLD is not accepted. It is accepted on the first IDLE cycle, giving a minimum spacing of WAIT_CYC+3 cycles between acceptances.
- Req, Addr, WData and ByteEn changes while Busy=1 are ignored.
- A is held at its last value in IDLE.
- Data_Mem is driven only during a write in SETUP, STROBE or HOLD. It is never driven on a read, so there is no bus contention.

Optional Feature:
- Macro: SRAM_CTRL_STATS_EN.
- Defined:
  - AccessCount increments by 1 on every Ready pulse, including no-ops.
  - 16-bit counter; 0xFFFF wraps to 0x0000.
  - Cleared by reset.
- Undefined: AccessCount is tied to 0 and the counter logic is not instantiated.

Test Plan:
- Reset with strobes mid-write (Reset=0 during STROBE) -> next cycle: all strobes = 1, Data_Mem = Z, Busy = 0, Ready = 0.
- Read of addr 0x00123, ByteEn = 11, SRAM model returning 0xBEEF, WAIT_CYC = 2 -> OE low for exactly 2 cycles, Ready at the 4th cycle after acceptance, RData = 0xBEEF.
- Write of 0xA55A to 0x0FFFF with ByteEn = 01 -> UB = 1, LB = 0, WE low for 2 cycles, data driven SETUP..HOLD, model location low byte = 0x5A, upper byte unchanged.
- Req held high continuously for reads of 0x00001 then 0x00002 -> second acceptance exactly 5 cycles after the first; inputs changed mid-access are ignored.
- ByteEn = 00 request -> Ready next cycle, CE/OE/WE stay 1, Busy stays 0.
- With SRAM_CTRL_STATS_EN defined and the counter preloaded via 65535 accesses -> one more access wraps AccessCount to 0x0000. Without the macro, AccessCount stays 0.
